// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the eight-client round-robin arbiter.
// Purely combinational helpers; no latency, no flow control.
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    idx2onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_enc_lsb8.sv
// Lowest-set-bit encoder over eight request lines.
// Combinational, zero latency; idx is 0 when no bit is set.
module prio_enc_lsb8
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight clients: grant held until owner drops req; 1-cycle grant/release latency,
// one idle cycle between owners. RR_ARB_TIMEOUT_EN adds a MAX_HOLD limit with a timeout pulse.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
`ifdef RR_ARB_TIMEOUT_EN
  output logic               timeout,
`endif
  output logic               gnt_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
  end

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic               gnt_valid_q;

  logic [NUM_REQ-1:0] masked;
  logic [IDX_W-1:0]   m_idx, r_idx, winner;
  logic               m_any, r_any;
  logic               owner_req;
  logic               force_rel;

  // Clients below the pointer lose priority until the raw fallback picks them.
  assign masked = req & (8'hFF << ptr_q);

  prio_enc_lsb8 u_enc_masked (.req_i(masked), .idx_o(m_idx), .any_o(m_any));
  prio_enc_lsb8 u_enc_raw    (.req_i(req),    .idx_o(r_idx), .any_o(r_any));

  assign winner    = m_any ? m_idx : r_idx;
  assign owner_req = req[gnt_idx_q];

`ifdef RR_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;

  assign force_rel = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign timeout   = timeout_q;
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef RR_ARB_TIMEOUT_EN
          timeout_q <= 1'b0;
          hold_q    <= '0;
`endif
          if (r_any) begin
            gnt_q       <= idx2onehot(winner);
            gnt_idx_q   <= winner;
            gnt_valid_q <= 1'b1;
            state_q     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A voluntary release on the limit cycle wins, so no timeout pulse then.
          if (!owner_req || force_rel) begin
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + IDX_W'(1);
            state_q     <= ST_IDLE;
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q   <= owner_req;
`endif
          end
`ifdef RR_ARB_TIMEOUT_EN
          else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8; the timeout section follows RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
`ifdef RR_ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
`ifdef RR_ARB_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_idx);
    check({tag, ".gnt"},   gnt, exp_gnt);
    check({tag, ".idx"},   {5'd0, gnt_idx}, {5'd0, exp_idx});
    check({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, (exp_gnt != 8'h00)});
  endtask

  task automatic check_ptr(input string tag, input logic [2:0] exp);
    check(tag, {5'd0, dut.ptr_q}, {5'd0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] bit_k;
    rst = 1'b1;
    req = 8'h00;

    // Reset state
    step(2);
    check_grant("reset", 8'h00, 3'd0);
    check_ptr("reset.ptr", 3'd0);
    rst = 1'b0;
    step(1);
    check_grant("idle_noreq", 8'h00, 3'd0);

    // Single request
    req = 8'h08;
    step(1);
    check_grant("single", 8'h08, 3'd3);
    req = 8'h00;
    step(1);
    check_grant("single_rel", 8'h00, 3'd0);
    check_ptr("single_rel.ptr", 3'd4);

    // Owner 2 drops as client 1 asserts; masked empty, fall back to raw
    req = 8'h04;
    step(1);
    check_grant("simul_own2", 8'h04, 3'd2);
    req = 8'h02;
    step(1);
    check_grant("simul_rel", 8'h00, 3'd0);
    check_ptr("simul_rel.ptr", 3'd3);
    step(1);
    check_grant("simul_fallback", 8'h02, 3'd1);
    req = 8'h00;
    step(1);
    check_ptr("simul_end.ptr", 3'd2);

    // Pointer wrap
    req = 8'h40;
    step(1);
    check_grant("wrap_g6", 8'h40, 3'd6);
    req = 8'h00;
    step(1);
    check_ptr("wrap_ptr7", 3'd7);
    req = 8'h41;
    step(1);
    check_grant("wrap_to0", 8'h01, 3'd0);
    req = 8'h00;
    step(1);
    check_ptr("wrap_ptr1", 3'd1);
    req = 8'h41;
    step(1);
    check_grant("wrap_to6", 8'h40, 3'd6);
    req = 8'h00;
    step(1);
    check_ptr("wrap_ptr7b", 3'd7);

    // Reset mid-grant: ptr 7, only client 5 requests
    req = 8'h20;
    step(1);
    check_grant("rstmid_own5", 8'h20, 3'd5);
    #2 rst = 1'b1;
    #1;
    check_grant("rstmid_async", 8'h00, 3'd0);
    check_ptr("rstmid_ptr", 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_grant("rstmid_held", 8'h00, 3'd0);
    step(1);
    check_grant("rstmid_regrant", 8'h20, 3'd5);
    req = 8'h00;
    step(1);
    check_ptr("rstmid_ptr6", 3'd6);

    // Full contention from ptr 0: order 0..7,0 with one idle cycle between
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      bit_k = 8'h01 << (k % 8);
      step(1);
      check_grant($sformatf("cont%0d.arb", k), bit_k, 3'(k % 8));
      step(1);
      check($sformatf("cont%0d.hold1", k), gnt, bit_k);
      step(1);
      check($sformatf("cont%0d.hold2", k), gnt, bit_k);
      req = 8'hFF & ~bit_k;
      step(1);
      check_grant($sformatf("cont%0d.idle", k), 8'h00, 3'd0);
      req = 8'hFF;
    end
    req = 8'h00;
    step(1);

    // Hold limit with req=0x03 held high
    do_reset();
    req = 8'h03;
    step(1);
    check_grant("hold_g0", 8'h01, 3'd0);
`ifdef RR_ARB_TIMEOUT_EN
    check("hold_to_low0", {7'd0, timeout}, 8'h00);
    for (int c = 1; c < 4; c++) begin
      step(1);
      check($sformatf("hold_g0_c%0d", c), gnt, 8'h01);
    end
    step(1);
    check_grant("to_rel0", 8'h00, 3'd0);
    check("to_pulse0", {7'd0, timeout}, 8'h01);
    check_ptr("to_ptr1", 3'd1);
    step(1);
    check_grant("to_g1", 8'h02, 3'd1);
    check("to_pulse_clr", {7'd0, timeout}, 8'h00);
    for (int c = 1; c < 4; c++) begin
      step(1);
      check($sformatf("to_g1_c%0d", c), gnt, 8'h02);
    end
    step(1);
    check_grant("to_rel1", 8'h00, 3'd0);
    check("to_pulse1", {7'd0, timeout}, 8'h01);
    // Voluntary release on the limit cycle: no timeout pulse
    req = 8'h01;
    step(1);
    check_grant("lim_g0", 8'h01, 3'd0);
    step(3);
    req = 8'h00;
    step(1);
    check_grant("lim_rel", 8'h00, 3'd0);
    check("lim_no_pulse", {7'd0, timeout}, 8'h00);
`else
    for (int c = 1; c < 20; c++) begin
      step(1);
      check($sformatf("hold_g0_c%0d", c), gnt, 8'h01);
    end
`endif
    req = 8'h00;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester round-robin arbiter that shares a single downstream resource (bus port, datapath slot) between up to eight clients. It uses priority-encoder logic on a rotating mask to pick the next owner. The grant is held until the owner drops its request, and optionally until a hold-time limit expires. It sits between the requesting clients and the shared resource's select/mux input.

## Interface
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only when RR_ARB_TIMEOUT_EN is defined; legal range 2..255
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  per-client request level; bit i = client i
- gnt  output  8  one-hot grant, registered; all-zero when idle
- gnt_idx  output  3  binary index of the granted client; 0 when idle
- gnt_valid  output  1  high while any grant is asserted (equals |gnt)
- timeout  output  1  one-cycle pulse on forced release; present only with RR_ARB_TIMEOUT_EN

One clock; reset is asynchronous and active-high.

## Operation
- State register: IDLE, GRANT. Pointer register ptr[2:0] holds the highest-priority index.
- Arbitration happens only in IDLE:
  - masked = req with bits below ptr cleared
  - winner = lowest set bit of masked if masked is nonzero, else lowest set bit of req
- IDLE with req != 0: at the edge, gnt = one-hot(winner), gnt_idx = winner, state goes to GRANT.
- IDLE with req == 0: stay in IDLE; outputs stay zero.
- GRANT with req[gnt_idx] == 1 and no timeout: hold. Changes on other req bits are ignored.
- GRANT with req[gnt_idx] == 0: at the edge, clear gnt, gnt_idx and gnt_valid; ptr = gnt_idx + 1 (mod 8, wraps 7 to 0); state goes to IDLE.
- Between consecutive grants there is always exactly one idle cycle (gnt_valid low), even if other requests are pending.
- Requests may drop without having been granted; the arbiter does not queue them.
- ptr changes only on release, never in IDLE.

## Timing
- Reset values: state IDLE, ptr 0, gnt 0, gnt_idx 0, gnt_valid 0, timeout 0, hold counter 0. Reset takes effect immediately (asynchronous), including in the middle of a grant.
- Latency from req sampled in IDLE to gnt asserted: 1 cycle.
- Latency from owner deasserting req to gnt cleared: 1 cycle.
- Minimum request-to-grant cycle for a waiting client is 2 cycles after the current owner releases: one release edge, then one arbitration edge.
- Outputs are driven only from registers; there is no combinational path from req to gnt.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and the owner still requests, the next edge forces release exactly as a normal release (ptr = gnt_idx + 1, go to IDLE) and pulses timeout high for that one cycle.
  - A normal release on the same cycle as the limit takes precedence: no timeout pulse.
- RR_ARB_TIMEOUT_EN undefined:
  - No counter and no timeout port.
  - The grant is held indefinitely while the owner requests; MAX_HOLD is ignored.

## Structure
- Package rr_arb_pkg:
  - NUM_REQ = 8
  - IDX_W = 3
  - state enum {ST_IDLE, ST_GRANT}
  - HOLD_W = 8
- Sub-module prio_enc_lsb8: combinational 8-bit lowest-set-bit encoder with outputs idx[2:0] and any.
  - Instantiated twice: once on masked, once on raw req.
  - The top level selects between the two results.

## Test plan
- Reset mid-grant: owner is client 5; assert rst between edges -> gnt=0, gnt_valid=0, ptr=0 immediately. After release of rst with req=0x20 -> gnt=0x20 one edge later.
- Single request: req=0x08 from IDLE -> next edge gnt=0x08, gnt_idx=3. Drop req -> next edge gnt=0, ptr=4.
- Full contention: req=0xFF, and each owner drops its bit for one cycle after 3 grant cycles and then re-asserts -> grant order 0,1,2,...,7,0 with one idle cycle between grants.
- Pointer wrap: after a grant to 6 (ptr=7), req=0x41 -> grant goes to 0, not 6. After that release, req=0x41 -> grant goes to 6.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=4), req=0x03 held high:
  - gnt=0x01 for 4 cycles with timeout pulsing on the release edge.
  - Then 1 idle cycle.
  - Then gnt=0x02 for 4 cycles.
  - Without the macro, gnt stays at 0x01 indefinitely.
- Simultaneous events: owner 2 drops its request on the same cycle that client 1 asserts (req 0x04 -> 0x02) -> release edge clears gnt, ptr=3. Next edge gnt=0x02, because masked is empty and arbitration falls back to raw req.
